// File: rtl/uart_rx_sipo.sv
// ============================================================================
// uart_rx_sipo : oversampled 8N1-style serial receiver with parallel output,
//                one-cycle valid strobe and framing-error pulse.
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx_sipo #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             rx_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             frame_error_o,
  output logic             busy_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] C_BIT_LAST  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Counters only advance in the timed states, so they never wrap while idling.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cyc_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (cyc_q == C_HALF_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == C_FULL_LAST) begin
          cyc_d = '0;
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_q == BIT_W'(i)) shift_d[i] = rx_s;
          end
          if (bit_q == C_BIT_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cyc_q == C_FULL_LAST) begin
          cyc_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign frame_error_o = ferr_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
// ============================================================================
// tb_uart_rx_sipo : scoreboard bench for uart_rx_sipo (8/16 and 7/4 builds).
// Revision        : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_sipo;

  typedef struct {
    logic       ferr;
    logic [7:0] d;
    int         t;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    int         gap;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] data;
  logic       valid, ferr, busy;
  logic [6:0] data7;
  logic       valid7, ferr7, busy7;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] last_good = 8'h00;
  exp_t q[$];
  exp_t q7[$];
  vec_t vecs[5];

  uart_rx_sipo #(.WIDTH(8), .CLKS_PER_BIT(16)) dut (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx),
    .data_o(data), .valid_o(valid), .frame_error_o(ferr), .busy_o(busy)
  );

  uart_rx_sipo #(.WIDTH(7), .CLKS_PER_BIT(4)) dut7 (
    .clk_i(clk), .reset_ni(reset_n), .rx_i(rx7),
    .data_o(data7), .valid_o(valid7), .frame_error_o(ferr7), .busy_o(busy7)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx7 = v;
    else     rx  = v;
    repeat (n) tick();
  endtask

  // Expected pulse time: 2 sync + half bit + (w+1) bits + 1 registered output.
  task automatic send(input bit sel, input logic [7:0] d, input logic stopv);
    int   w;
    int   cpb;
    exp_t e;
    w      = sel ? 7 : 8;
    cpb    = sel ? 4 : 16;
    e.t    = cyc + 2 + cpb / 2 + (w + 1) * cpb + 1;
    e.ferr = ~stopv;
    e.d    = stopv ? d : last_good;
    if (sel) q7.push_back(e);
    else begin
      q.push_back(e);
      if (stopv) last_good = d;
    end
    drive(sel, 1'b0, cpb);
    for (int k = 0; k < w; k++) drive(sel, d[k], cpb);
    drive(sel, stopv, cpb);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid && ferr) check("valid_ferr_exclusive", 1, 0);
    if (valid || ferr) begin
      if (q.size() == 0) check("unexpected_pulse", {valid, ferr}, 0);
      else begin
        e = q.pop_front();
        check("pulse_kind", ferr, e.ferr);
        check("pulse_data", data, e.d);
        check("pulse_time", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid7 || ferr7) begin
      if (q7.size() == 0) check("w7_unexpected_pulse", {valid7, ferr7}, 0);
      else begin
        e = q7.pop_front();
        check("w7_pulse_kind", ferr7, e.ferr);
        check("w7_pulse_data", data7, e.d[6:0]);
        check("w7_pulse_time", cyc, e.t);
      end
    end
  end

  initial begin
    #1000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int c;
    vecs[0] = '{8'h99, 20};
    vecs[1] = '{8'h61, 0};
    vecs[2] = '{8'hA5, 20};
    vecs[3] = '{8'h00, 20};
    vecs[4] = '{8'hFF, 20};

    repeat (3) tick();
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", ferr, 0);
    check("rst_busy", busy, 0);
    check("rst_busy_w7", busy7, 0);
    reset_n = 1'b1;
    repeat (5) tick();

    for (int i = 0; i < 5; i++) begin
      send(1'b0, vecs[i].d, 1'b1);
      repeat (vecs[i].gap) tick();
    end

    // glitch: 4 low cycles at the pin are gone by the mid-start sample
    c = cyc;
    drive(1'b0, 1'b0, 4);
    rx = 1'b1;
    wait_until(c + 10);
    check("glitch_busy_start", busy, 1);
    tick();
    check("glitch_busy_after", busy, 0);
    repeat (20) tick();
    send(1'b0, 8'h3C, 1'b1);
    repeat (10) tick();

    // framing error followed by a held-low line
    send(1'b0, 8'h99, 1'b1);
    repeat (10) tick();
    c = cyc;
    send(1'b0, 8'h0F, 1'b0);
    wait_until(c + 190);
    check("wait_high_busy", busy, 1);
    wait_until(c + 200);
    rx = 1'b1;
    wait_until(c + 202);
    check("wait_high_busy_late", busy, 1);
    tick();
    check("wait_high_exit", busy, 0);
    check("ferr_data_kept", data, 8'h99);
    repeat (10) tick();
    send(1'b0, 8'h55, 1'b1);
    repeat (10) tick();

    // reset during data bit 3 of a 0xC3 frame
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b0, 8);
    check("pre_reset_busy", busy, 1);
    rx = 1'b1;
    reset_n = 1'b0;
    tick();
    check("mid_rst_data", data, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_ferr", ferr, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    last_good = 8'h00;
    repeat (20) tick();
    check("post_rst_busy", busy, 0);
    send(1'b0, 8'hC3, 1'b1);
    repeat (10) tick();

    send(1'b1, 8'h5A, 1'b1);
    repeat (20) tick();

    check("q_drained", q.size(), 0);
    check("w7_q_drained", q7.size(), 0);
    check("final_data", data, 8'hC3);
    check("final_data_w7", data7, 7'h5A);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_sipo.md
# uart_rx_sipo

Serial-in, parallel-out UART receiver, the receive-side counterpart of the parallel-in, serial-out transmit shifter. It recovers 8N1-style frames from an asynchronous serial line by oversampling with a bit-period counter, then presents each received word on a parallel bus with a one-cycle valid strobe. It sits between the external RX pin and the host-side consumer logic. Framing errors are flagged, and the block resynchronises to the next frame without intervention.

## Interface
- WIDTH, 8: data bits per frame.
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be an even number, at least 4.
- clk  input  1  system clock. All logic is on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge.
- rx  input  1  asynchronous serial line. Idle is high.
- data  output  WIDTH  last correctly framed word. Bit 0 is the first bit received.
- valid  output  1  one-cycle pulse when data updates.
- frame_error  output  1  one-cycle pulse when a stop bit is sampled low.
- busy  output  1  high in any state other than IDLE.

## Operation
- rx passes through a 2-flop synchronizer, giving rx_s. A reset value of 1 is loaded into both flops.
- Frame format: start bit (0), then WIDTH data bits LSB first, then one stop bit (1). There is no parity bit.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: on rx_s == 0, clear the bit counter and the cycle counter, then go to START.
- START: count CLKS_PER_BIT/2 cycles to reach mid-bit, then sample rx_s.
  - rx_s == 1 means a false start (glitch). Return to IDLE with no output activity.
  - rx_s == 0 means a valid start. Go to DATA.
- DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register bit index bit_cnt (LSB first). After WIDTH samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - rx_s == 1: load data from the shift register, pulse valid, go to IDLE.
  - rx_s == 0: pulse frame_error, leave data unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from being read as a stream of 0x00 frames.
- The cycle counter width is clog2(CLKS_PER_BIT). The bit counter width is clog2(WIDTH+1).
  - Both counters reset to 0 on every state entry.
  - Neither counter wraps inside a state.
- valid and frame_error are never high in the same cycle.
- Reset values: data = 0, valid = 0, frame_error = 0, busy = 0, FSM = IDLE, shift register = 0, synchronizer = 1.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values in the cycle after the sampled reset. The next falling edge after reset is released starts a fresh frame.

## Timing
- The synchronizer latency is 2 cycles. Let T0 be the first cycle in which rx_s is seen low in IDLE.
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit k sample: T0 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT, for k = 0..WIDTH-1.
- Stop sample: T0 + CLKS_PER_BIT/2 + (WIDTH+1)·CLKS_PER_BIT.
- valid, frame_error and the data update are registered. They are visible in the cycle after the stop sample.
- Defaults (WIDTH = 8, CLKS_PER_BIT = 16):
  - valid is high at T0 + 153.
  - This is 155 cycles after the rx falling edge at the pin.
- The FSM returns to IDLE in the same edge that asserts valid. A start bit that begins right after a full stop bit is detected.
- busy: high from T0+1 until the FSM re-enters IDLE.

## Test plan
- Single frame: drive 0x99 (serial order 1,0,0,1,1,0,0,1 between start and stop) with CLKS_PER_BIT = 16 clocks per bit. Required: data = 0x99, valid high for exactly 1 cycle at T0 + 153, frame_error stays 0.
- Back-to-back frames: 0x61 immediately followed by 0xA5, with no idle gap after the stop bit. Required: two valid pulses 160 cycles apart, carrying data 0x61 then 0xA5.
- Glitch rejection: hold rx low for 4 cycles, then high. Required: no valid and no frame_error, busy falls after the start sample, and a following 0x3C frame is received correctly.
- Framing error: send 0x99 successfully, then send 0x0F with the stop bit low, then hold rx low for 40 more cycles. Required:
  - one frame_error pulse, with data still 0x99;
  - busy stays high in WAIT_HIGH until rx returns high;
  - a following 0x55 frame yields valid with data = 0x55.
- Reset mid-operation: assert reset (low) for 2 cycles during data bit 3 of a frame. Required: data = 0, valid = 0, busy = 0 after reset, no pulse for the truncated frame, and the next full 0xC3 frame is received correctly.
- Parameter sweep: WIDTH = 7 and CLKS_PER_BIT = 4, with frame 0x5A. Required: valid at T0 + 2 + 8·4 + 1 = T0 + 35, with data = 0x5A.
